// File: rtl/ec_time_counter.sv
// Free-running 64-bit tick counter (1 tick = 3125/512 ns) that resynchronises to the EtherCAT DC time.
// A bit-serial restoring divider converts ns to ticks, and the load is compensated for the conversion latency.
module ec_time_counter #(
    parameter int MUL_SHIFT = 9,
    parameter int DIVISOR   = 3125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] ecat_sync_time,
    input  logic        sync_set,
    output logic [63:0] sys_time,
    output logic        sync_done,
    output logic        synced,
    output logic        busy
);
    localparam int LAT = 64 + MUL_SHIFT + 3;
    localparam int DW  = 64 + MUL_SHIFT;
    localparam int RW  = 13;
    localparam int CW  = $clog2(DW);
    localparam logic [RW:0] DIVISOR_W = (RW + 1)'(DIVISOR);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_ADD  = 2'd2;
    localparam logic [1:0] ST_LOAD = 2'd3;

    logic [1:0]    state_reg;
    logic [63:0]   sys_time_reg;
    logic          sync_done_reg;
    logic          synced_reg;
    logic          busy_reg;
    logic [DW-1:0] dividend_reg;
    logic [RW-1:0] rem_reg;
    logic [63:0]   quot_reg;
    logic [CW-1:0] bit_cnt_reg;
    logic [63:0]   tgt_reg;

    logic [RW:0]   trial;
    logic          trial_ge;
    logic [RW:0]   rem_next;

    // Restoring step: bring down the next dividend bit and subtract if it fits.
    always_comb begin
        trial    = {rem_reg, dividend_reg[DW-1]};
        trial_ge = (trial >= DIVISOR_W);
        rem_next = trial_ge ? (trial - DIVISOR_W) : trial;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            sys_time_reg  <= '0;
            sync_done_reg <= 1'b0;
            synced_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            dividend_reg  <= '0;
            rem_reg       <= '0;
            quot_reg      <= '0;
            bit_cnt_reg   <= '0;
            tgt_reg       <= '0;
        end else begin
            sync_done_reg <= 1'b0;
            sys_time_reg  <= sys_time_reg + 64'd1;
            // A new request always wins, aborting any conversion in flight.
            if (sync_set) begin
                dividend_reg <= {ecat_sync_time, {MUL_SHIFT{1'b0}}};
                rem_reg      <= '0;
                quot_reg     <= '0;
                bit_cnt_reg  <= CW'(DW - 1);
                busy_reg     <= 1'b1;
                state_reg    <= ST_DIV;
            end else begin
                case (state_reg)
                    ST_DIV: begin
                        rem_reg      <= rem_next[RW-1:0];
                        quot_reg     <= {quot_reg[62:0], trial_ge};
                        dividend_reg <= {dividend_reg[DW-2:0], 1'b0};
                        if (bit_cnt_reg == '0) begin
                            state_reg <= ST_ADD;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg - 1'b1;
                        end
                    end
                    ST_ADD: begin
                        tgt_reg   <= quot_reg + 64'(LAT);
                        state_reg <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        sys_time_reg  <= tgt_reg;
                        sync_done_reg <= 1'b1;
                        synced_reg    <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign sys_time  = sys_time_reg;
    assign sync_done = sync_done_reg;
    assign synced    = synced_reg;
    assign busy      = busy_reg;
endmodule
